// File: rtl/uart_sample_framer_if.sv
// Opcode/transmitter handshake and frame status bundle for uart_sample_framer.
interface uart_sample_framer_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       frame_done;
  logic       timeout_err;

  modport master (
    output rx_data, rx_ready, tx_ready,
    input  tx_data, tx_start, busy, frame_done, timeout_err
  );

  modport slave (
    input  rx_data, rx_ready, tx_ready,
    output tx_data, tx_start, busy, frame_done, timeout_err
  );
endinterface

// File: rtl/uart_sample_framer.sv
// Opcode-driven framer: snapshots four channel samples and streams a SYNC/OP/data/CHK frame to a UART tx.
// Optional macro SEQ_NUM_EN inserts an 8-bit frame sequence byte after the OP/NAK byte.
module uart_sample_framer #(
  parameter int unsigned SAMPLE_W     = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [SAMPLE_W-1:0] ch1_sample,
  input  logic [SAMPLE_W-1:0] ch2_sample,
  input  logic [SAMPLE_W-1:0] ch3_sample,
  input  logic [SAMPLE_W-1:0] ch4_sample,
  uart_sample_framer_if.slave bus
);

  localparam int unsigned TMO_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [7:0]  NAK_BYTE = 8'hEE;
  localparam logic [7:0]  OP_ALL   = 8'h0F;
`ifdef SEQ_NUM_EN
  localparam int unsigned HDR_LEN  = 3;
`else
  localparam int unsigned HDR_LEN  = 2;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rx_ready_q;
  logic [7:0]          r_op;
  logic [SAMPLE_W-1:0] r_snap [4];
  logic [7:0]          r_chk, w_chk_nxt, w_chk_upd;
  logic [3:0]          r_idx, w_idx_nxt, w_gen_idx, w_last;
  logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
  logic [7:0]          r_tx_data, w_tx_data_nxt, w_gen_byte;
  logic                r_tx_start, w_tx_start_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_frame_done, w_frame_done_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;
  logic                w_rx_rise, w_accept, w_all, w_nak;
  logic [2:0]          w_k;
  logic [1:0]          w_ch;
  logic [SAMPLE_W-1:0] w_smp;
`ifdef SEQ_NUM_EN
  logic [7:0]          r_seq;
`endif

  assign w_rx_rise = bus.rx_ready & ~r_rx_ready_q;
  assign w_gen_idx = r_idx + 4'd1;
  assign w_chk_upd = (r_idx == 4'd0) ? r_chk : (r_chk ^ r_tx_data);

  // Frame shape decoded from the latched opcode
  always_comb begin : frame_shape
    w_all = (r_op == OP_ALL);
    w_nak = !w_all && !((r_op >= 8'h01) && (r_op <= 8'h04));
    if (w_all)      w_last = 4'(HDR_LEN + 8);
    else if (w_nak) w_last = 4'(HDR_LEN + 1);
    else            w_last = 4'(HDR_LEN + 2);
  end

  // Byte to present at the index following the current one
  always_comb begin : gen_byte
    w_k        = 3'(w_gen_idx - 4'(HDR_LEN));
    w_ch       = w_all ? w_k[2:1] : 2'(r_op[1:0] - 2'd1);
    w_smp      = r_snap[w_ch];
    w_gen_byte = w_k[0] ? w_smp[7:0] : 8'(w_smp >> 8);
    if (w_gen_idx == w_last)     w_gen_byte = w_chk_upd;
    else if (w_gen_idx == 4'd1)  w_gen_byte = w_nak ? NAK_BYTE : r_op;
`ifdef SEQ_NUM_EN
    else if (w_gen_idx == 4'd2)  w_gen_byte = r_seq;
`endif
    else if (w_nak)              w_gen_byte = r_op;
  end

  always_comb begin : fsm_comb
    w_state_nxt       = r_state;
    w_accept          = 1'b0;
    w_idx_nxt         = r_idx;
    w_chk_nxt         = r_chk;
    w_tmo_nxt         = r_tmo;
    w_tx_data_nxt     = r_tx_data;
    w_tx_start_nxt    = 1'b0;
    w_busy_nxt        = r_busy;
    w_frame_done_nxt  = 1'b0;
    w_timeout_err_nxt = r_timeout_err;
    case (r_state)
      S_IDLE: begin
        if (w_rx_rise) begin
          w_accept          = 1'b1;
          w_state_nxt       = S_LOAD;
          w_busy_nxt        = 1'b1;
          w_timeout_err_nxt = 1'b0;
          w_tx_data_nxt     = SYNC_BYTE;
          w_idx_nxt         = 4'd0;
          w_chk_nxt         = 8'd0;
        end
      end
      S_LOAD: begin
        if (bus.tx_ready) begin
          w_tx_start_nxt = 1'b1;
          w_tmo_nxt      = '0;
          w_state_nxt    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end else if (r_tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never took the byte; resend it unchanged
          w_timeout_err_nxt = 1'b1;
          w_state_nxt       = S_LOAD;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (r_idx == w_last) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_DONE;
          end else begin
            w_chk_nxt     = w_chk_upd;
            w_idx_nxt     = w_gen_idx;
            w_tx_data_nxt = w_gen_byte;
            w_state_nxt   = S_LOAD;
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin : state_reg
    if (!reset_b) begin
      r_state       <= S_IDLE;
      r_rx_ready_q  <= 1'b0;
      r_idx         <= '0;
      r_chk         <= '0;
      r_tmo         <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rx_ready_q  <= bus.rx_ready;
      r_idx         <= w_idx_nxt;
      r_chk         <= w_chk_nxt;
      r_tmo         <= w_tmo_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  // Coherent opcode and sample snapshot taken on accept
  always_ff @(posedge clk or negedge reset_b) begin : snap_reg
    if (!reset_b) begin
      r_op <= '0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else if (w_accept) begin
      r_op      <= bus.rx_data;
      r_snap[0] <= ch1_sample;
      r_snap[1] <= ch2_sample;
      r_snap[2] <= ch3_sample;
      r_snap[3] <= ch4_sample;
    end
  end

`ifdef SEQ_NUM_EN
  always_ff @(posedge clk or negedge reset_b) begin : seq_reg
    if (!reset_b)               r_seq <= '0;
    else if (r_state == S_DONE) r_seq <= r_seq + 8'd1;
  end
`endif

  assign bus.tx_data     = r_tx_data;
  assign bus.tx_start    = r_tx_start;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Scoreboard bench for uart_sample_framer with a behavioural UART transmitter model.
module tb_uart_sample_framer;

  localparam int unsigned SAMPLE_W     = 10;
  localparam logic [7:0]  SYNC_BYTE    = 8'hA5;
  localparam int unsigned BUSY_TIMEOUT = 1023;
`ifdef SEQ_NUM_EN
  localparam int SEQ = 1;
`else
  localparam int SEQ = 0;
`endif

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  logic [SAMPLE_W-1:0] ch1, ch2, ch3, ch4;

  uart_sample_framer_if bus();

  uart_sample_framer #(
    .SAMPLE_W(SAMPLE_W), .SYNC_BYTE(SYNC_BYTE), .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk(clk), .reset_b(reset_b),
    .ch1_sample(ch1), .ch2_sample(ch2), .ch3_sample(ch3), .ch4_sample(ch4),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int n_bytes = 0;
  int n_pushed = 0;
  int n_done = 0;
  int ign_cyc = 0;
  bit ignore_next = 0;
  bit retry_pending = 0;
  logic [7:0] tb_seq = 8'd0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected frame for an opcode against the current samples and sequence model
  task automatic push_frame(input logic [7:0] op);
    logic [7:0] body[$];
    logic [7:0] c;
    logic [15:0] s[4];
    int n;
    s[0] = 16'(ch1); s[1] = 16'(ch2); s[2] = 16'(ch3); s[3] = 16'(ch4);
    if (op >= 8'h01 && op <= 8'h04) begin
      n = int'(op) - 1;
      body.push_back(op);
      if (SEQ != 0) body.push_back(tb_seq);
      body.push_back(s[n][15:8]);
      body.push_back(s[n][7:0]);
    end else if (op == 8'h0F) begin
      body.push_back(op);
      if (SEQ != 0) body.push_back(tb_seq);
      for (int i = 0; i < 4; i++) begin
        body.push_back(s[i][15:8]);
        body.push_back(s[i][7:0]);
      end
    end else begin
      body.push_back(8'hEE);
      if (SEQ != 0) body.push_back(tb_seq);
      body.push_back(op);
    end
    c = 8'd0;
    foreach (body[i]) c = c ^ body[i];
    exp_q.push_back(SYNC_BYTE);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(c);
    n_pushed += body.size() + 2;
  endtask

  task automatic send_op(input logic [7:0] op, input bit accept);
    @(negedge clk);
    if (accept) push_frame(op);
    bus.rx_data  = op;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int t = 0;
    while (!bus.frame_done && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_done_seen", 32'(bus.frame_done), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    check({tag, "_timeout_err"}, 32'(bus.timeout_err), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: drops tx_ready 3 cycles after start, idles again 40 later
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (reset_b && bus.tx_start) begin
        n_starts++;
        if (ignore_next) begin
          ignore_next   = 0;
          retry_pending = 1;
          ign_cyc       = cyc;
          check("ignored_byte", 32'(bus.tx_data), 32'(SYNC_BYTE));
        end else begin
          if (retry_pending) begin
            retry_pending = 0;
            check("retry_gap", 32'((cyc - ign_cyc >= 1023) && (cyc - ign_cyc <= 1027)), 1);
            check("timeout_err_set", 32'(bus.timeout_err), 1);
          end
          n_bytes++;
          if (exp_q.size() == 0) check("sb_extra_byte", 32'(exp_q.size()), 1);
          else                   check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          repeat (3) @(negedge clk);
          bus.tx_ready = 1'b0;
          repeat (40) @(negedge clk);
          bus.tx_ready = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.frame_done) begin
      n_done++;
      tb_seq = tb_seq + 8'd1;
      check("busy_at_done", 32'(bus.busy), 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;
    bus.rx_data = 8'h00;
    bus.rx_ready = 1'b0;
    ch1 = 10'h000; ch2 = 10'h2B7; ch3 = 10'h000; ch4 = 10'h000;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Single channel 2
    s0 = n_starts; d0 = n_done;
    send_op(8'h02, 1);
    check("busy_after_accept", 32'(bus.busy), 1);
    wait_frame(2000);
    @(negedge clk);
    check("op02_starts", 32'(n_starts - s0), 32'(5 + SEQ));
    check("op02_done_count", 32'(n_done - d0), 1);
    check("op02_busy_low", 32'(bus.busy), 0);
    check("op02_queue_empty", 32'(exp_q.size()), 0);

    // All channels with samples changed mid-frame
    ch1 = 10'h3FF; ch2 = 10'h000; ch3 = 10'h155; ch4 = 10'h2AA;
    send_op(8'h0F, 1);
    repeat (150) @(negedge clk);
    ch1 = 10'h0AA; ch2 = 10'h111; ch3 = 10'h222; ch4 = 10'h333;
    wait_frame(4000);
    @(negedge clk);
    check("op0F_queue_empty", 32'(exp_q.size()), 0);
    check("op0F_bytes", 32'(n_bytes), 32'(n_pushed));

    // NAK
    send_op(8'h7E, 1);
    wait_frame(2000);
    @(negedge clk);
    check("nak_timeout_err", 32'(bus.timeout_err), 0);
    check("nak_queue_empty", 32'(exp_q.size()), 0);

    // Edge while busy is dropped; opcode in first IDLE cycle is accepted
    d0 = n_done; s0 = n_starts;
    send_op(8'h01, 1);
    repeat (20) @(negedge clk);
    send_op(8'h03, 0);
    wait_frame(2000);
    send_op(8'h03, 1);
    check("b2b_busy", 32'(bus.busy), 1);
    wait_frame(2000);
    @(negedge clk);
    check("b2b_done_count", 32'(n_done - d0), 2);
    check("b2b_starts", 32'(n_starts - s0), 32'(2 * (5 + SEQ)));
    check("b2b_queue_empty", 32'(exp_q.size()), 0);

    // Transmitter ignores the first start; byte is retried after the timeout
    s0 = n_starts;
    ignore_next = 1;
    send_op(8'h04, 1);
    repeat (500) @(negedge clk);
    check("tmo_not_early", 32'(bus.timeout_err), 0);
    wait_frame(4000);
    @(negedge clk);
    check("tmo_starts", 32'(n_starts - s0), 32'(6 + SEQ));
    check("tmo_sticky", 32'(bus.timeout_err), 1);
    check("tmo_queue_empty", 32'(exp_q.size()), 0);
    send_op(8'h01, 1);
    check("tmo_cleared", 32'(bus.timeout_err), 0);
    wait_frame(2000);
    @(negedge clk);

    // Reset during the third byte of a frame
    s0 = n_bytes;
    send_op(8'h0F, 1);
    for (int t = 0; t < 2000 && n_bytes < s0 + 3; t++) @(negedge clk);
    check("reached_byte3", 32'(n_bytes - s0), 3);
    repeat (10) @(negedge clk);
    reset_b = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    n_pushed = n_bytes;
    tb_seq = 8'd0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (60) @(negedge clk);
    ch2 = 10'h1C3;
    send_op(8'h02, 1);
    wait_frame(2000);
    send_op(8'h02, 1);
    wait_frame(2000);
    @(negedge clk);
    check("post_reset_queue_empty", 32'(exp_q.size()), 0);
    check("post_reset_bytes", 32'(n_bytes), 32'(n_pushed));
    check("post_reset_seq_model", 32'(tb_seq), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_sample_framer.md
Name: uart_sample_framer

Overview:
- Command-driven framer between the UART receive/transmit pair and the per-channel max-value datapath.
- On a received opcode, snapshots all four channel samples and emits a framed, checksummed multi-byte packet through the UART transmitter, one byte at a time.
- Replaces single-byte transmission of a truncated sample: full-resolution samples and multi-channel dumps per request.

Parameters:
- SAMPLE_W, 10, sample width in bits; legal range 9..16.
- SYNC_BYTE, 8'hA5, first byte of every frame.
- BUSY_TIMEOUT, 1023, clk cycles to wait for tx_ready to fall after a start pulse before retrying the byte.

Ports:
- clk  in  1  system clock.
- reset_b  in  1  asynchronous active-low reset.
- rx_data  in  8  received opcode byte; valid when rx_ready=1.
- rx_ready  in  1  opcode-valid strobe; level or pulse, edge-detected internally.
- ch1_sample, ch2_sample, ch3_sample, ch4_sample  in  SAMPLE_W  current channel values.
- tx_ready  in  1  transmitter idle (1) / shifting (0).
- tx_data  out  8  byte presented to transmitter.
- tx_start  out  1  one-cycle load/start strobe to transmitter.
- busy  out  1  high from frame accept until frame_done.
- frame_done  out  1  one-cycle pulse after the last byte completes.
- timeout_err  out  1  sticky error: at least one start retry occurred; cleared by the next accepted opcode.

Behaviour:
- Reset values: tx_data=0, tx_start=0, busy=0, frame_done=0, timeout_err=0, state=IDLE, all snapshots, checksum and byte index cleared.
- Opcode accept:
  - Rising edge of rx_ready in IDLE accepts the opcode.
  - Same cycle: latch rx_data and all four samples (coherent snapshot), clear the checksum, set busy=1 on the next cycle.
  - rx_ready edges while busy=1 are ignored and dropped; no queueing.
- Opcodes and frame contents:
  - 8'h01..8'h04 (single channel N): SYNC, OP, HI(N), LO(N), CHK. 5 bytes.
  - 8'h0F (all channels): SYNC, OP, HI(1), LO(1), HI(2), LO(2), HI(3), LO(3), HI(4), LO(4), CHK. 11 bytes.
  - Any other value (NAK): SYNC, 8'hEE, OP, CHK. 4 bytes.
- Byte formats:
  - HI = sample[SAMPLE_W-1:8] zero-extended to 8 bits.
  - LO = sample[7:0].
  - CHK = XOR of every byte after SYNC, up to but excluding CHK.
- State machine:
  - IDLE: wait for the accept condition above.
  - LOAD: drive tx_data = current byte. When tx_ready=1, pulse tx_start for exactly 1 cycle and go to WAIT_BUSY; otherwise hold in LOAD.
  - WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE. If the counter reaches BUSY_TIMEOUT first: set timeout_err, return to LOAD, resend the same byte without changing the checksum.
  - WAIT_DONE: wait for tx_ready=1. Then XOR the byte into the checksum (except SYNC and CHK) and advance the index. Go to LOAD if bytes remain, else DONE.
  - DONE: frame_done=1 for 1 cycle, busy=0 next cycle, return to IDLE.
- tx_data holds stable from LOAD entry through WAIT_DONE exit.
- Latency: first tx_start no earlier than 2 cycles after the accepted rx_ready edge.
- Samples changing mid-frame have no effect; the snapshot is used.
- Reset assertion mid-frame aborts immediately to reset values. No partial-frame recovery; the host resynchronises on SYNC.
- Back-to-back: a new opcode is accepted in the first IDLE cycle after DONE.

Optional Feature:
- Macro SEQ_NUM_EN.
- Defined:
  - An 8-bit sequence counter (reset 0) is inserted as a byte directly after OP, or after 8'hEE in NAK frames.
  - The sequence byte is included in CHK.
  - Counter increments by 1 at every frame_done and wraps 255->0.
  - Frame lengths become 6 / 12 / 5 bytes.
- Undefined: no counter logic; frames exactly as above.

Test Plan:
- Opcode 8'h02, ch2=10'h2B7, tx_ready model drops 3 cycles after start and rises 40 later -> bytes A5,02,02,B7,B7; exactly 5 tx_start pulses; one frame_done pulse.
- Opcode 8'h0F, ch1..4 = 10'h3FF,10'h000,10'h155,10'h2AA -> A5,0F,03,FF,00,00,01,55,02,AA,CHK=8'h0F^03^FF^00^00^01^55^02^AA. Samples change mid-frame: output unchanged.
- Opcode 8'h7E -> A5,EE,7E,90; timeout_err=0.
- Second rx_ready edge while busy -> ignored, only one frame sent; opcode after frame_done -> accepted, new frame.
- tx_ready held 1 after first start pulse -> after 1023 cycles timeout_err=1 and byte A5 re-strobed. Model then responds -> frame completes; next accepted opcode clears timeout_err.
- reset_b pulsed low mid-byte 3 -> all outputs 0 immediately, IDLE; next opcode yields a full frame. With SEQ_NUM_EN, sequence byte reads 00, then 01 on the following frame.
